// File: rtl/vblank_arbiter.sv
// Framebuffer port arbiter: display fetches always win, two round-robin writers are admitted
// only inside the vertical-blanking window, and every grant is a fixed-length burst.
module vblank_arbiter #(
    parameter int BURST_LEN    = 16,
    parameter int VBLANK_LINES = 18,
    parameter int GUARD_LINES  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_line_tick,
    input  logic       i_vde,
    input  logic       i_rd_req,
    input  logic [1:0] i_wr_req,
    output logic       o_rd_gnt,
    output logic [1:0] o_wr_gnt,
    output logic       o_busy,
    output logic       o_wr_window,
    output logic       o_rd_late
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BW = $clog2(VBLANK_LINES + 1);

    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);
    localparam logic [BW-1:0] BLANK_MAX  = BW'(VBLANK_LINES);
    localparam logic [BW-1:0] OPEN_LIMIT = BW'(VBLANK_LINES - GUARD_LINES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_TURN
    } state_t;

    state_t          state_q,     state_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [BW-1:0]   blank_cnt_q, blank_cnt_d;
    logic            wr_ptr_q,    wr_ptr_d;
    logic            rd_gnt_q,    rd_gnt_d;
    logic [1:0]      wr_gnt_q,    wr_gnt_d;
    logic            busy_q,      busy_d;
    logic            wr_window_q, wr_window_d;
    logic            rd_late_q,   rd_late_d;
    logic            wr_pick;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_gnt_d    = rd_gnt_q;
        wr_gnt_d    = wr_gnt_q;

        // A lone requester wins outright; the pointer only breaks ties.
        wr_pick = (i_wr_req == 2'b11) ? wr_ptr_q : i_wr_req[1];

        case (state_q)
            S_IDLE: begin
                burst_cnt_d = '0;
                if (i_rd_req) begin
                    state_d  = S_RD;
                    rd_gnt_d = 1'b1;
                end else if (wr_window_q && (i_wr_req != 2'b00)) begin
                    state_d  = S_WR;
                    wr_gnt_d = wr_pick ? 2'b10 : 2'b01;
                    wr_ptr_d = ~wr_pick;
                end
            end
            S_RD, S_WR: begin
                if (burst_cnt_q == BURST_LAST) begin
                    state_d     = S_TURN;
                    burst_cnt_d = '0;
                    rd_gnt_d    = 1'b0;
                    wr_gnt_d    = 2'b00;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                burst_cnt_d = '0;
                rd_gnt_d    = 1'b0;
                wr_gnt_d    = 2'b00;
            end
        endcase

        busy_d = rd_gnt_d | (|wr_gnt_d);

        if (i_vde) begin
            blank_cnt_d = '0;
        end else if (i_line_tick && (blank_cnt_q < BLANK_MAX)) begin
            blank_cnt_d = blank_cnt_q + 1'b1;
        end else begin
            blank_cnt_d = blank_cnt_q;
        end

        // The closing guard lines keep an admitted burst from running into active video.
        wr_window_d = ~i_vde & (blank_cnt_q < OPEN_LIMIT);
        rd_late_d   = i_line_tick & i_rd_req & ~rd_gnt_q;
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            state_q     <= S_IDLE;
            burst_cnt_q <= '0;
            blank_cnt_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_gnt_q    <= 1'b0;
            wr_gnt_q    <= 2'b00;
            busy_q      <= 1'b0;
            wr_window_q <= 1'b0;
            rd_late_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_gnt_q    <= rd_gnt_d;
            wr_gnt_q    <= wr_gnt_d;
            busy_q      <= busy_d;
            wr_window_q <= wr_window_d;
            rd_late_q   <= rd_late_d;
        end
    end

    assign o_rd_gnt    = rd_gnt_q;
    assign o_wr_gnt    = wr_gnt_q;
    assign o_busy      = busy_q;
    assign o_wr_window = wr_window_q;
    assign o_rd_late   = rd_late_q;

endmodule

// File: tb/tb_vblank_arbiter.sv
// Directed bench for vblank_arbiter: a per-cycle vector table for bursts, round robin and priority,
// plus hand-written sequences for the guard window, blanking-counter clear and saturation.
module tb_vblank_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_tick;
    logic       vde;
    logic       rd_req;
    logic [1:0] wr_req;
    logic       rd_gnt;
    logic [1:0] wr_gnt;
    logic       busy;
    logic       wr_window;
    logic       rd_late;

    int n_checks = 0;
    int n_fail   = 0;

    vblank_arbiter #(
        .BURST_LEN   (16),
        .VBLANK_LINES(18),
        .GUARD_LINES (1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_line_tick(line_tick),
        .i_vde      (vde),
        .i_rd_req   (rd_req),
        .i_wr_req   (wr_req),
        .o_rd_gnt   (rd_gnt),
        .o_wr_gnt   (wr_gnt),
        .o_busy     (busy),
        .o_wr_window(wr_window),
        .o_rd_late  (rd_late)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         reps;
        logic       rst;
        logic       tick;
        logic       vde;
        logic       rd;
        logic [1:0] wr;
        logic       e_rd;
        logic [1:0] e_wr;
        logic       e_win;
        logic       e_late;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input int reps, input logic r, input logic t, input logic vd,
                               input logic rd, input logic [1:0] wr, input logic e_rd,
                               input logic [1:0] e_wr, input logic e_win, input logic e_late);
        vec_t x;
        x.reps = reps; x.rst = r; x.tick = t; x.vde = vd; x.rd = rd; x.wr = wr;
        x.e_rd = e_rd; x.e_wr = e_wr; x.e_win = e_win; x.e_late = e_late;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic t, input logic vd, input logic rd, input logic [1:0] wr);
        line_tick = t;
        vde       = vd;
        rd_req    = rd;
        wr_req    = wr;
    endtask

    initial begin
        int n_gnt;
        int n_win;

        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 2'b00);

        // reps, rst, tick, vde, rd, wr  |  exp rd, exp wr, exp window, exp late
        // Reset, then display bursts with the regrant gap, then reset mid-burst.
        vecs.push_back(v( 2, 1, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
        vecs.push_back(v( 1, 0, 0, 1, 1, 2'b00, 1, 2'b00, 0, 0));
        vecs.push_back(v(15, 0, 0, 1, 1, 2'b00, 1, 2'b00, 0, 0));
        vecs.push_back(v( 2, 0, 0, 1, 1, 2'b00, 0, 2'b00, 0, 0));
        vecs.push_back(v( 1, 0, 0, 1, 1, 2'b00, 1, 2'b00, 0, 0));
        vecs.push_back(v( 4, 0, 0, 1, 0, 2'b00, 1, 2'b00, 0, 0));
        vecs.push_back(v( 3, 1, 0, 1, 1, 2'b00, 0, 2'b00, 0, 0));
        vecs.push_back(v( 3, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
        // Blanking with both writers: window opens a cycle late, then wr0, wr1, wr0.
        vecs.push_back(v( 1, 0, 0, 0, 0, 2'b11, 0, 2'b00, 1, 0));
        vecs.push_back(v(16, 0, 0, 0, 0, 2'b11, 0, 2'b01, 1, 0));
        vecs.push_back(v( 2, 0, 0, 0, 0, 2'b11, 0, 2'b00, 1, 0));
        vecs.push_back(v(16, 0, 0, 0, 0, 2'b11, 0, 2'b10, 1, 0));
        vecs.push_back(v( 2, 0, 0, 0, 0, 2'b11, 0, 2'b00, 1, 0));
        vecs.push_back(v(16, 0, 0, 0, 0, 2'b11, 0, 2'b01, 1, 0));
        // Only wr1 requesting: granted twice in a row, the second time against the pointer.
        vecs.push_back(v( 2, 0, 0, 0, 0, 2'b10, 0, 2'b00, 1, 0));
        vecs.push_back(v(16, 0, 0, 0, 0, 2'b10, 0, 2'b10, 1, 0));
        vecs.push_back(v( 2, 0, 0, 0, 0, 2'b10, 0, 2'b00, 1, 0));
        vecs.push_back(v(16, 0, 0, 0, 0, 2'b10, 0, 2'b10, 1, 0));
        vecs.push_back(v( 4, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0));
        // wr0 burst; rd raised on grant cycle 3, tick on grant cycle 8, late pulse on cycle 9.
        vecs.push_back(v( 1, 0, 0, 0, 0, 2'b01, 0, 2'b01, 1, 0));
        vecs.push_back(v( 2, 0, 0, 0, 0, 2'b01, 0, 2'b01, 1, 0));
        vecs.push_back(v( 5, 0, 0, 0, 1, 2'b01, 0, 2'b01, 1, 0));
        vecs.push_back(v( 1, 0, 1, 0, 1, 2'b01, 0, 2'b01, 1, 1));
        vecs.push_back(v( 7, 0, 0, 0, 1, 2'b01, 0, 2'b01, 1, 0));
        vecs.push_back(v( 2, 0, 0, 0, 1, 2'b01, 0, 2'b00, 1, 0));
        // rd beats the still-pending wr0; afterwards the tie goes to wr1.
        vecs.push_back(v( 1, 0, 0, 0, 1, 2'b01, 1, 2'b00, 1, 0));
        vecs.push_back(v(15, 0, 0, 0, 0, 2'b11, 1, 2'b00, 1, 0));
        vecs.push_back(v( 2, 0, 0, 0, 0, 2'b11, 0, 2'b00, 1, 0));
        vecs.push_back(v( 1, 0, 0, 0, 0, 2'b11, 0, 2'b10, 1, 0));
        vecs.push_back(v(15, 0, 0, 0, 0, 2'b00, 0, 2'b10, 1, 0));
        vecs.push_back(v( 2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0));

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                rst = vecs[i].rst;
                drive(vecs[i].tick, vecs[i].vde, vecs[i].rd, vecs[i].wr);
                step();
                check($sformatf("vec%0d.%0d rd_gnt", i, r), 32'(rd_gnt), 32'(vecs[i].e_rd));
                check($sformatf("vec%0d.%0d wr_gnt", i, r), 32'(wr_gnt), 32'(vecs[i].e_wr));
                check($sformatf("vec%0d.%0d busy", i, r), 32'(busy),
                      32'(vecs[i].e_rd | (|vecs[i].e_wr)));
                check($sformatf("vec%0d.%0d wr_window", i, r), 32'(wr_window), 32'(vecs[i].e_win));
                check($sformatf("vec%0d.%0d rd_late", i, r), 32'(rd_late), 32'(vecs[i].e_late));
            end
        end
        rst = 1'b0;

        // Tick coincident with vde rising: the clear wins.
        drive(1'b1, 1'b1, 1'b0, 2'b00);
        step();
        check("clear_beats_tick", 32'(dut.blank_cnt_q), 32'd0);
        check("window_shut_vde", 32'(wr_window), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 2'b00);
        step();

        // Sixteen blank lines leave the window open.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b0, 2'b00);
            step();
            drive(1'b0, 1'b0, 1'b0, 2'b00);
            step();
        end
        check("window_open_16", 32'(wr_window), 32'd1);

        // Burst admitted just before the guard line; it must run its full length.
        drive(1'b0, 1'b0, 1'b0, 2'b01);
        step();
        check("guard_gnt_start", 32'(wr_gnt), 32'd1);
        step();
        drive(1'b1, 1'b0, 1'b0, 2'b01);
        step();
        check("window_at_tick17", 32'(wr_window), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 2'b01);
        step();
        check("window_closed", 32'(wr_window), 32'd0);
        n_gnt = 4;
        n_win = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (wr_gnt != 2'b00) n_gnt++;
            if (wr_window) n_win++;
        end
        check("guard_burst_len", 32'(n_gnt), 32'd16);
        check("guard_window_low", 32'(n_win), 32'd0);

        // Active video with a writer waiting: never granted.
        n_gnt = 0;
        for (int i = 0; i < 30; i++) begin
            drive((i == 5), 1'b1, 1'b0, 2'b01);
            step();
            if (wr_gnt != 2'b00) n_gnt++;
        end
        check("no_gnt_active", 32'(n_gnt), 32'd0);

        // Twenty-five blank lines saturate the counter at VBLANK_LINES.
        for (int i = 0; i < 25; i++) begin
            drive(1'b1, 1'b0, 1'b0, 2'b00);
            step();
            drive(1'b0, 1'b0, 1'b0, 2'b00);
            step();
        end
        check("blank_saturate", 32'(dut.blank_cnt_q), 32'd18);
        check("window_saturated", 32'(wr_window), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 2'b00);
        step();
        check("blank_cleared", 32'(dut.blank_cnt_q), 32'd0);
        check("window_after_clear", 32'(wr_window), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        step();
        check("window_reopens", 32'(wr_window), 32'd1);
        check("idle_at_end", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
